// File: rtl/decode_ri_mode_pkg.sv
// Shared defaults and state encodings for the JPEG-LS run-interruption decoder.
// Also holds the small helpers used by its FSM.
package decode_ri_mode_pkg;

  localparam int DEFAULT_MODRESIDUAL_LENGTH        = 9;
  localparam int DEFAULT_MAPPED_ERROR_VALUE_LENGTH = 10;
  localparam int DEFAULT_K_LENGTH                  = 4;
  localparam int DEFAULT_J_LENGTH                  = 5;
  localparam int DEFAULT_RUNCOUNT_LENGTH           = 16;
  localparam int DEFAULT_LIMIT                     = 32;
  localparam int DEFAULT_QBPP                      = 8;

  // Unary counter and bit counter widths; LIMIT must stay below 2**Q_LENGTH.
  localparam int Q_LENGTH   = 8;
  localparam int CNT_LENGTH = 8;

  typedef logic [2:0] ri_state_t;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] RUNBIT = 3'd1;
  localparam logic [2:0] RUNREM = 3'd2;
  localparam logic [2:0] UNARY  = 3'd3;
  localparam logic [2:0] REMAIN = 3'd4;
  localparam logic [2:0] ESCAPE = 3'd5;
  localparam logic [2:0] DONE   = 3'd6;

  // Unary threshold before the J[RUNindex] term is subtracted.
  function automatic int unary_threshold_base(input int limit, input int qbpp);
    return limit - qbpp - 2;
  endfunction

  function automatic logic takes_bits(input ri_state_t s);
    logic r;
    case (s)
      RUNBIT, RUNREM, UNARY, REMAIN, ESCAPE: r = 1'b1;
      default:                               r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/decode_ri_inverse_map.sv
// Inverse error mapping for run-interruption samples.
// Turns MErrval back into a signed errValue using RIType, k and the N/Nn comparison.
module decode_ri_inverse_map
  import decode_ri_mode_pkg::*;
#(
  parameter int modresidual_length        = DEFAULT_MODRESIDUAL_LENGTH,
  parameter int mapped_error_value_length = DEFAULT_MAPPED_ERROR_VALUE_LENGTH,
  parameter int k_length                  = DEFAULT_K_LENGTH
) (
  input  logic [mapped_error_value_length-1:0] merrval,
  input  logic                                 ri_type,
  input  logic [k_length-1:0]                  k,
  input  logic                                 n_nn_compare,
  output logic [modresidual_length-1:0]        err_value
);

  localparam int W = mapped_error_value_length + 1;

  logic [W-1:0] temp_s;
  logic [W-1:0] abs_s;
  logic [W-1:0] signed_s;
  logic         map_s;
  logic         neg_s;

  // One extra bit keeps MErrval+RIType+map from wrapping.
  always_comb begin
    temp_s = {1'b0, merrval} + {{(W-1){1'b0}}, ri_type};
    map_s  = temp_s[0];
    abs_s  = (temp_s + {{(W-1){1'b0}}, map_s}) >> 1;
    neg_s  = map_s ^ ((k == '0) && !n_nn_compare);
    if (abs_s == '0) begin
      signed_s = '0;
    end else if (neg_s) begin
      signed_s = -abs_s;
    end else begin
      signed_s = abs_s;
    end
    err_value = modresidual_length'(signed_s);
  end

endmodule

// File: rtl/decode_ri_mode.sv
// Bit-serial JPEG-LS run-interruption sample decoder: optional run remainder,
// Golomb prefix/suffix or limit-overflow escape, then inverse mapping.
module decode_ri_mode
  import decode_ri_mode_pkg::*;
#(
  parameter int modresidual_length        = DEFAULT_MODRESIDUAL_LENGTH,
  parameter int mapped_error_value_length = DEFAULT_MAPPED_ERROR_VALUE_LENGTH,
  parameter int k_length                  = DEFAULT_K_LENGTH,
  parameter int J_length                  = DEFAULT_J_LENGTH,
  parameter int runcount_length           = DEFAULT_RUNCOUNT_LENGTH,
  parameter int LIMIT                     = DEFAULT_LIMIT,
  parameter int qbpp                      = DEFAULT_QBPP
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          do_run_decoding,
  input  logic [k_length-1:0]           k,
  input  logic [J_length-1:0]           J,
  input  logic                          RIType,
  input  logic                          N_Nn_Compare,
  input  logic                          bit_in,
  input  logic                          bit_valid,
  output logic                          bit_ready,
  output logic [modresidual_length-1:0] err_value,
  output logic [runcount_length-1:0]    run_remainder,
  output logic                          limit_overflow,
  output logic                          done,
  output logic                          busy,
  output logic                          protocol_error
);

  localparam int M      = mapped_error_value_length;
  localparam int T_BASE = unary_threshold_base(LIMIT, qbpp);

  ri_state_t                     state_r, state_nxt_s;
  logic [k_length-1:0]           k_r;
  logic [J_length-1:0]           j_r;
  logic                          ri_type_r, cmp_r;
  logic [Q_LENGTH-1:0]           q_r;
  logic [CNT_LENGTH-1:0]         cnt_r;
  logic [M-1:0]                  merrval_r;
  logic signed [Q_LENGTH:0]      q_s, thr_s;
  logic                          xfer_s, last_bit_s, perr_s;
  logic [modresidual_length-1:0] map_err_s;

  logic                          bit_ready_r, busy_r, done_r, protocol_error_r, limit_overflow_r;
  logic [modresidual_length-1:0] err_value_r;
  logic [runcount_length-1:0]    run_remainder_r;

  decode_ri_inverse_map #(
    .modresidual_length       (modresidual_length),
    .mapped_error_value_length(mapped_error_value_length),
    .k_length                 (k_length)
  ) u_inverse_map (
    .merrval     (merrval_r),
    .ri_type     (ri_type_r),
    .k           (k_r),
    .n_nn_compare(cmp_r),
    .err_value   (map_err_s)
  );

  // Handshake and the signed unary threshold T = LIMIT - J - qbpp - 2.
  always_comb begin
    xfer_s     = bit_valid & bit_ready_r;
    last_bit_s = (cnt_r == CNT_LENGTH'(1));
    q_s        = $signed({1'b0, q_r});
    thr_s      = $signed((Q_LENGTH+1)'(T_BASE)) - $signed((Q_LENGTH+1)'(j_r));
  end

  // Next-state logic; illegal bits fall back to IDLE with perr_s raised.
  always_comb begin
    state_nxt_s = state_r;
    perr_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (!start) begin
          state_nxt_s = IDLE;
        end else if (do_run_decoding) begin
          state_nxt_s = RUNBIT;
        end else begin
          state_nxt_s = UNARY;
        end
      end
      RUNBIT: begin
        if (!xfer_s) begin
          state_nxt_s = RUNBIT;
        end else if (bit_in) begin
          perr_s      = 1'b1;
          state_nxt_s = IDLE;
        end else if (j_r != '0) begin
          state_nxt_s = RUNREM;
        end else begin
          state_nxt_s = UNARY;
        end
      end
      RUNREM, REMAIN, ESCAPE: begin
        if (!(xfer_s && last_bit_s)) begin
          state_nxt_s = state_r;
        end else if (state_r == RUNREM) begin
          state_nxt_s = UNARY;
        end else begin
          state_nxt_s = DONE;
        end
      end
      UNARY: begin
        if (!xfer_s) begin
          state_nxt_s = UNARY;
        end else if (!bit_in) begin
          if (q_s >= thr_s) begin
            perr_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = UNARY;
          end
        end else if (q_s < thr_s) begin
          if (k_r != '0) begin
            state_nxt_s = REMAIN;
          end else begin
            state_nxt_s = DONE;
          end
        end else if (q_s == thr_s) begin
          state_nxt_s = ESCAPE;
        end else begin
          perr_s      = 1'b1;
          state_nxt_s = IDLE;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, latched sample context, counters, shift registers and outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r          <= IDLE;
      k_r              <= '0;
      j_r              <= '0;
      ri_type_r        <= 1'b0;
      cmp_r            <= 1'b0;
      q_r              <= '0;
      cnt_r            <= '0;
      merrval_r        <= '0;
      bit_ready_r      <= 1'b0;
      busy_r           <= 1'b0;
      done_r           <= 1'b0;
      protocol_error_r <= 1'b0;
      limit_overflow_r <= 1'b0;
      err_value_r      <= '0;
      run_remainder_r  <= '0;
    end else begin
      state_r          <= state_nxt_s;
      bit_ready_r      <= takes_bits(state_nxt_s);
      busy_r           <= (state_nxt_s != IDLE);
      done_r           <= (state_r == DONE);
      protocol_error_r <= perr_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            k_r              <= k;
            j_r              <= J;
            ri_type_r        <= RIType;
            cmp_r            <= N_Nn_Compare;
            q_r              <= '0;
            merrval_r        <= '0;
            run_remainder_r  <= '0;
            limit_overflow_r <= 1'b0;
          end
        end
        RUNBIT: begin
          if (xfer_s) cnt_r <= CNT_LENGTH'(j_r);
        end
        RUNREM: begin
          if (xfer_s) begin
            run_remainder_r <= {run_remainder_r[runcount_length-2:0], bit_in};
            cnt_r           <= cnt_r - CNT_LENGTH'(1);
          end
        end
        UNARY: begin
          if (xfer_s) begin
            if (!bit_in) begin
              q_r <= q_r + Q_LENGTH'(1);
            end else if (state_nxt_s == ESCAPE) begin
              cnt_r            <= CNT_LENGTH'(qbpp);
              merrval_r        <= '0;
              limit_overflow_r <= 1'b1;
            end else begin
              // Seeding with q lets the k suffix bits shift in to form (q<<k)|r.
              cnt_r     <= CNT_LENGTH'(k_r);
              merrval_r <= M'(q_r);
            end
          end
        end
        REMAIN: begin
          if (xfer_s) begin
            merrval_r <= {merrval_r[M-2:0], bit_in};
            cnt_r     <= cnt_r - CNT_LENGTH'(1);
          end
        end
        ESCAPE: begin
          if (xfer_s) begin
            cnt_r <= cnt_r - CNT_LENGTH'(1);
            if (last_bit_s) begin
              merrval_r <= {merrval_r[M-2:0], bit_in} + M'(1);
            end else begin
              merrval_r <= {merrval_r[M-2:0], bit_in};
            end
          end
        end
        DONE:    err_value_r <= map_err_s;
        default: ;
      endcase
    end
  end

  assign bit_ready      = bit_ready_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign protocol_error = protocol_error_r;
  assign limit_overflow = limit_overflow_r;
  assign err_value      = err_value_r;
  assign run_remainder  = run_remainder_r;

endmodule

// File: tb/tb_decode_ri_mode.sv
// Bench for decode_ri_mode: directed cases plus randomized samples built from
// (q, r, v, run remainder) and compared against an arithmetic reference model.
module tb_decode_ri_mode;

  logic        clk = 1'b0;
  logic        reset, start, do_run_decoding, RIType, N_Nn_Compare, bit_in, bit_valid;
  logic [3:0]  k;
  logic [4:0]  J;
  logic        bit_ready, limit_overflow, done, busy, protocol_error;
  logic [8:0]  err_value;
  logic [15:0] run_remainder;

  decode_ri_mode dut (
    .clk(clk), .reset(reset), .start(start), .do_run_decoding(do_run_decoding),
    .k(k), .J(J), .RIType(RIType), .N_Nn_Compare(N_Nn_Compare),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .err_value(err_value), .run_remainder(run_remainder),
    .limit_overflow(limit_overflow), .done(done), .busy(busy),
    .protocol_error(protocol_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic signed [63:0] got,
                           input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Sample description and expectations.
  bit         stim_q[$];
  bit         cfg_dr, cfg_rit, cfg_cmp;
  int         cfg_j, cfg_k;
  bit         exp_perr, exp_lo;
  int         exp_rr;
  logic [8:0] exp_err9;
  int         stall_at = -1, stall_len = 0, stall_pct = 0;
  bit         rand_start = 1'b0;
  int         lat_r;

  function automatic int unary_limit(input int j);
    return 32 - j - 1 - 8 - 1;
  endfunction

  function automatic int model_err(input int mer, input int rit, input int kk, input int cmpv);
    int temp, mp, mag, neg;
    temp = mer + rit;
    mp   = temp % 2;
    mag  = (temp + mp) / 2;
    neg  = mp ^ ((kk == 0 && cmpv == 0) ? 1 : 0);
    if (mag == 0) return 0;
    return (neg != 0) ? -mag : mag;
  endfunction

  task automatic push_bits(input int value, input int n);
    for (int i = n - 1; i >= 0; i--) stim_q.push_back(((value >> i) & 1) == 1);
  endtask

  task automatic begin_case(input bit dr, input int j, input int kk, input bit rit,
                            input bit cmpv, input int rr);
    cfg_dr = dr; cfg_j = j; cfg_k = kk; cfg_rit = rit; cfg_cmp = cmpv;
    stim_q.delete();
    exp_perr = 1'b0; exp_lo = 1'b0; exp_err9 = 9'd0;
    exp_rr = dr ? rr : 0;
    if (dr) begin
      stim_q.push_back(1'b0);
      push_bits(rr, j);
    end
  endtask

  task automatic add_normal(input int q, input int r);
    repeat (q) stim_q.push_back(1'b0);
    stim_q.push_back(1'b1);
    push_bits(r, cfg_k);
    exp_err9 = 9'(model_err(((q << cfg_k) | r) & 1023, int'(cfg_rit), cfg_k, int'(cfg_cmp)));
  endtask

  task automatic add_escape(input int v);
    repeat (unary_limit(cfg_j)) stim_q.push_back(1'b0);
    stim_q.push_back(1'b1);
    push_bits(v, 8);
    exp_lo   = 1'b1;
    exp_err9 = 9'(model_err(v + 1, int'(cfg_rit), cfg_k, int'(cfg_cmp)));
  endtask

  task automatic add_overflow();
    repeat (unary_limit(cfg_j) + 1) stim_q.push_back(1'b0);
    exp_perr = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, ":bit_ready"}, bit_ready, 0);
    check_val({tag, ":busy"}, busy, 0);
    check_val({tag, ":done"}, done, 0);
    check_val({tag, ":perr"}, protocol_error, 0);
    check_val({tag, ":err_value"}, err_value, 0);
    check_val({tag, ":run_rem"}, run_remainder, 0);
    check_val({tag, ":lim_ovf"}, limit_overflow, 0);
  endtask

  task automatic run_sample(input string tag);
    int first, last, stalls, idx, guard, done_cyc, perr_cyc, done_cnt, st_done;
    logic [8:0]  got_err;
    logic [15:0] got_rr;
    logic        got_lo;
    first = -1; last = -1; stalls = 0; idx = 0; guard = 0;
    done_cyc = -1; perr_cyc = -1; done_cnt = 0; st_done = 0;
    got_err = '0; got_rr = '0; got_lo = 1'b0;
    @(negedge clk);
    k = 4'(cfg_k); J = 5'(cfg_j); RIType = cfg_rit; N_Nn_Compare = cfg_cmp;
    do_run_decoding = cfg_dr; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Context must have been latched: scramble it.
    k = 4'($urandom); J = 5'($urandom); RIType = 1'($urandom);
    N_Nn_Compare = 1'($urandom); do_run_decoding = 1'($urandom);
    check_val({tag, ":busy_rise"}, busy, 1);
    while (idx < stim_q.size() && guard < 400) begin
      guard++;
      if (rand_start) start = 1'($urandom);
      if (bit_ready && !(idx == stall_at && st_done < stall_len) &&
          ($urandom_range(0, 99) >= stall_pct)) begin
        bit_valid = 1'b1; bit_in = stim_q[idx];
        if (first < 0) first = cyc;
        last = cyc; idx++;
      end else begin
        bit_valid = 1'b0; bit_in = 1'($urandom);
        if (first >= 0) stalls++;
        if (idx == stall_at) st_done++;
      end
      @(negedge clk);
    end
    check_val({tag, ":all_bits"}, idx, stim_q.size());
    bit_valid = 1'b0; start = 1'b0;
    for (int w = 0; w < 6; w++) begin
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; got_err = err_value; got_rr = run_remainder; got_lo = limit_overflow;
        end
      end
      if (protocol_error && perr_cyc < 0) perr_cyc = cyc;
      @(negedge clk);
    end
    if (exp_perr) begin
      check_val({tag, ":perr_time"}, perr_cyc, last + 1);
      check_val({tag, ":no_done"}, done_cnt, 0);
    end else begin
      check_val({tag, ":latency"}, done_cyc - first, stim_q.size() + 1 + stalls);
      check_val({tag, ":done_pulses"}, done_cnt, 1);
      check_val({tag, ":err_value"}, got_err, exp_err9);
      check_val({tag, ":run_rem"}, got_rr, exp_rr);
      check_val({tag, ":lim_ovf"}, got_lo, exp_lo);
      check_val({tag, ":no_perr"}, perr_cyc, -1);
    end
    check_val({tag, ":idle_after"}, busy, 0);
    lat_r = done_cyc - first;
  endtask

  initial begin
    int sc, j, kk, rr;
    bit dr;
    reset = 1'b1; start = 1'b0; do_run_decoding = 1'b0; k = 4'd0; J = 5'd0;
    RIType = 1'b0; N_Nn_Compare = 1'b0; bit_in = 1'b0; bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    begin_case(1'b0, 0, 2, 1'b0, 1'b0, 0); add_normal(1, 2); exp_err9 = 9'd3;
    run_sample("normal");
    check_val("normal:cycles", lat_r, 5);

    begin_case(1'b1, 3, 0, 1'b1, 1'b0, 5); add_normal(2, 0); exp_err9 = 9'd2;
    run_sample("run_prefix");

    begin_case(1'b0, 1, 3, 1'b0, 1'b0, 0); add_escape(8'h2C); exp_err9 = 9'h1E9;
    run_sample("escape");

    begin_case(1'b1, 2, 1, 1'b0, 1'b0, 0); stim_q.delete(); stim_q.push_back(1'b1);
    exp_perr = 1'b1;
    run_sample("runbit_err");

    begin_case(1'b0, 1, 1, 1'b0, 1'b0, 0); add_overflow();
    run_sample("unary_ovf");

    begin_case(1'b0, 0, 1, 1'b0, 1'b0, 0); add_normal(0, 0); exp_err9 = 9'd0;
    run_sample("zero_err");

    begin_case(1'b0, 0, 2, 1'b0, 1'b0, 0); add_normal(1, 2); exp_err9 = 9'd3;
    stall_at = 1; stall_len = 3;
    run_sample("stall");
    check_val("stall:cycles", lat_r, 8);
    stall_at = -1; stall_len = 0;

    // Abort a decode while in REMAIN.
    @(negedge clk);
    k = 4'd2; J = 5'd0; RIType = 1'b0; N_Nn_Compare = 1'b0; do_run_decoding = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
    @(negedge clk);
    bit_in = 1'b1;
    @(negedge clk);
    bit_valid = 1'b0;
    check_val("rst_mid:in_remain", bit_ready, 1);
    reset = 1'b1;
    #1;
    check_idle_outputs("rst_mid");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("rst_mid:no_done", done, 0);
    begin_case(1'b0, 0, 2, 1'b0, 1'b0, 0); add_normal(1, 2); exp_err9 = 9'd3;
    run_sample("after_rst");
    check_val("after_rst:cycles", lat_r, 5);

    stall_pct = 20; rand_start = 1'b1;
    for (int n = 0; n < 150; n++) begin
      sc = $urandom_range(0, 9);
      dr = 1'($urandom_range(0, 1));
      j  = $urandom_range(0, 15);
      kk = $urandom_range(0, 4);
      rr = int'($urandom) & ((1 << j) - 1);
      if (sc == 0) dr = 1'b1;
      begin_case(dr, j, kk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rr);
      if (sc == 0) begin
        stim_q.delete(); stim_q.push_back(1'b1); exp_perr = 1'b1;
      end else if (sc == 1) begin
        add_overflow();
      end else if (sc <= 3) begin
        add_escape($urandom_range(0, 255));
      end else begin
        add_normal($urandom_range(0, unary_limit(j) - 1), int'($urandom) & ((1 << kk) - 1));
      end
      run_sample("rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
